// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and a hardware
// return-address stack with sticky overflow/underflow flags.
module fetch_stage #(
    parameter int PC_W      = 12,
    parameter int INSTR_W   = 32,
    parameter int RAS_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               flush,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               call,
    input  logic               ret,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [PC_W-1:0]    if_id_pc,
    output logic               if_id_valid,
    output logic               ras_empty,
    output logic               stack_overflow,
    output logic               stack_underflow
);
    localparam int IDX_W = $clog2(RAS_DEPTH);
    localparam int SP_W  = IDX_W + 1;

    logic [PC_W-1:0]    pc_reg, pc_next;
    logic [INSTR_W-1:0] instr_reg, instr_next;
    logic [PC_W-1:0]    ifpc_reg, ifpc_next;
    logic               valid_reg, valid_next;
    logic [SP_W-1:0]    sp_reg, sp_next;
    logic               ovf_reg, ovf_next;
    logic               unf_reg, unf_next;

    logic [PC_W-1:0]    ras [RAS_DEPTH];
    logic               push_en;
    logic [IDX_W-1:0]   push_idx;
    logic [PC_W-1:0]    push_data;
    logic [IDX_W-1:0]   top_idx;
    logic [PC_W-1:0]    ras_top;
    logic               ras_full;
    logic               pop_ok;

    assign push_idx  = sp_reg[IDX_W-1:0];
    assign push_data = ifpc_reg + PC_W'(1);
    assign top_idx   = IDX_W'(sp_reg - SP_W'(1));
    assign ras_top   = ras[top_idx];
    assign ras_full  = (sp_reg >= SP_W'(RAS_DEPTH));
    assign pop_ok    = ret && (sp_reg != '0);

    always_comb begin
        pc_next    = pc_reg;
        instr_next = instr_reg;
        ifpc_next  = ifpc_reg;
        valid_next = valid_reg;
        sp_next    = sp_reg;
        ovf_next   = ovf_reg;
        unf_next   = unf_reg;
        push_en    = 1'b0;

        if (call) begin
            if (!ras_full) begin
                push_en = 1'b1;
                sp_next = sp_reg + SP_W'(1);
            end else begin
                ovf_next = 1'b1;
            end
            pc_next    = redirect_pc;
            instr_next = '0;
            ifpc_next  = '0;
            valid_next = 1'b0;
        end else if (pop_ok) begin
            pc_next    = ras_top;
            sp_next    = sp_reg - SP_W'(1);
            instr_next = '0;
            ifpc_next  = '0;
            valid_next = 1'b0;
        end else begin
            // A return on an empty stack only raises the flag; fetch carries on normally.
            if (ret) begin
                unf_next = 1'b1;
            end
            if (redirect) begin
                pc_next    = redirect_pc;
                instr_next = '0;
                ifpc_next  = '0;
                valid_next = 1'b0;
            end else begin
                if (!stall) begin
                    pc_next    = pc_reg + PC_W'(1);
                    instr_next = imem_data;
                    ifpc_next  = pc_reg;
                    valid_next = 1'b1;
                end
                if (flush) begin
                    instr_next = '0;
                    ifpc_next  = '0;
                    valid_next = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg    <= '0;
            instr_reg <= '0;
            ifpc_reg  <= '0;
            valid_reg <= 1'b0;
            sp_reg    <= '0;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
        end else begin
            pc_reg    <= pc_next;
            instr_reg <= instr_next;
            ifpc_reg  <= ifpc_next;
            valid_reg <= valid_next;
            sp_reg    <= sp_next;
            ovf_reg   <= ovf_next;
            unf_reg   <= unf_next;
        end
    end

    // Stack storage carries no reset; stale entries are unreachable once sp is cleared.
    always_ff @(posedge clk) begin
        if (!rst && push_en) begin
            ras[push_idx] <= push_data;
        end
    end

    assign imem_addr       = pc_reg;
    assign if_id_instr     = instr_reg;
    assign if_id_pc        = ifpc_reg;
    assign if_id_valid     = valid_reg;
    assign ras_empty       = (sp_reg == '0);
    assign stack_overflow  = ovf_reg;
    assign stack_underflow = unf_reg;
endmodule
